// File: rtl/result_drain.sv
`default_nettype none
// ============================================================================
// result_drain: snapshots systolic-array results on done, streams them out
// with row/col/last tags. Macro RESULT_DRAIN_COLMAJOR_EN selects column-major.
// Revision: 1.0
// ============================================================================
module result_drain #(
  parameter int RESULT_WIDTH = 16,
  parameter int ROWS         = 4,
  parameter int COLS         = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                done,
  input  logic [ROWS*COLS*RESULT_WIDTH-1:0]   results,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [RESULT_WIDTH-1:0]             out_data,
  output logic [(ROWS>1?$clog2(ROWS):1)-1:0]  out_row,
  output logic [(COLS>1?$clog2(COLS):1)-1:0]  out_col,
  output logic                                out_last,
  output logic                                busy,
  output logic                                overrun
);

  localparam int N     = ROWS * COLS;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    overrun_q, overrun_d;
  logic                    capture;
  logic [RESULT_WIDTH-1:0] shadow_q [N];

  logic xfer;
  logic final_beat;
  int   row_i, col_i, addr_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      overrun_q <= 1'b0;
      for (int i = 0; i < N; i++) shadow_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      overrun_q <= overrun_d;
      if (capture) begin
        for (int i = 0; i < N; i++)
          shadow_q[i] <= results[i*RESULT_WIDTH +: RESULT_WIDTH];
      end
    end
  end

  assign final_beat = (idx_q == IDX_W'(N - 1));
  assign xfer       = (state_q == S_STREAM) && out_ready;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    overrun_d = overrun_q;
    capture   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (done) begin
          state_d = S_STREAM;
          idx_d   = '0;
          capture = 1'b1;
        end
      end
      S_STREAM: begin
        if (xfer && final_beat) begin
          // A done coinciding with the last handshake starts the next matrix seamlessly.
          idx_d = '0;
          if (done) capture = 1'b1;
          else      state_d = S_IDLE;
        end else begin
          if (xfer) idx_d = idx_q + IDX_W'(1);
          if (done) overrun_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
`ifdef RESULT_DRAIN_COLMAJOR_EN
    row_i = int'(idx_q) % ROWS;
    col_i = int'(idx_q) / ROWS;
`else
    row_i = int'(idx_q) / COLS;
    col_i = int'(idx_q) % COLS;
`endif
    addr_i = row_i * COLS + col_i;
  end

  assign out_data  = shadow_q[IDX_W'(addr_i)];
  assign out_row   = ROW_W'(row_i);
  assign out_col   = COL_W'(col_i);
  assign out_valid = (state_q == S_STREAM);
  assign busy      = (state_q == S_STREAM);
  assign out_last  = (state_q == S_STREAM) && final_beat;
  assign overrun   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_result_drain.sv
`default_nettype none
// ============================================================================
// tb_result_drain: table vectors, directed corner sequences and random traffic
// against a queue-based model. Honours RESULT_DRAIN_COLMAJOR_EN.
// Revision: 1.0
// ============================================================================
module tb_result_drain;
  localparam int RW = 16;
  localparam int R  = 4;
  localparam int C  = 4;
  localparam int N  = R * C;

  logic            clk = 1'b0;
  logic            rst, done, out_ready;
  logic [N*RW-1:0] results;
  logic            out_valid, out_last, busy, overrun;
  logic [RW-1:0]   out_data;
  logic [1:0]      out_row, out_col;

  always #5 clk = ~clk;

  result_drain #(.RESULT_WIDTH(RW), .ROWS(R), .COLS(C)) dut (
    .clk(clk), .rst(rst), .done(done), .results(results),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_col(out_col), .out_last(out_last),
    .busy(busy), .overrun(overrun)
  );

  typedef struct {
    logic [RW-1:0] data;
    int            row;
    int            col;
    bit            last;
  } beat_t;

  beat_t q[$];
  bit    m_ovr = 1'b0;
  int    total = 0;
  int    bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void beat_rc(input int k, output int r, output int c);
`ifdef RESULT_DRAIN_COLMAJOR_EN
    r = k % R;
    c = k / R;
`else
    r = k / C;
    c = k % C;
`endif
  endfunction

  function automatic int exp_data(input int base, input int k);
    int r, c;
    beat_rc(k, r, c);
    return base + r*C + c + 1;
  endfunction

  function automatic logic [N*RW-1:0] pat(input int base);
    logic [N*RW-1:0] v;
    for (int i = 0; i < N; i++) v[i*RW +: RW] = RW'(base + i + 1);
    return v;
  endfunction

  function automatic logic [N*RW-1:0] rnd_res();
    logic [N*RW-1:0] v;
    for (int i = 0; i < N*RW/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic model_load(input logic [N*RW-1:0] res);
    for (int k = 0; k < N; k++) begin
      beat_t b;
      int r, c;
      beat_rc(k, r, c);
      b.data = res[(r*C + c)*RW +: RW];
      b.row  = r;
      b.col  = c;
      b.last = (k == N-1);
      q.push_back(b);
    end
  endtask

  task automatic model_edge(input bit r, input bit d, input bit rdy, input logic [N*RW-1:0] res);
    bit idle, hs, fin;
    idle = (q.size() == 0);
    hs   = !idle && rdy;
    fin  = hs && (q.size() == 1);
    if (r) begin
      q.delete();
      m_ovr = 1'b0;
    end else begin
      if (hs) void'(q.pop_front());
      if (d) begin
        if (idle || fin) model_load(res);
        else             m_ovr = 1'b1;
      end
    end
  endtask

  task automatic check_outputs();
    chk("out_valid", out_valid, q.size() != 0);
    chk("busy", busy, q.size() != 0);
    chk("overrun", overrun, m_ovr);
    if (q.size() != 0) begin
      chk("out_data", out_data, q[0].data);
      chk("out_row", out_row, q[0].row);
      chk("out_col", out_col, q[0].col);
      chk("out_last", out_last, q[0].last);
    end else begin
      chk("out_last_idle", out_last, 0);
    end
  endtask

  task automatic cyc(input bit r, input bit d, input bit rdy, input logic [N*RW-1:0] res);
    rst = r; done = d; out_ready = rdy; results = res;
    @(posedge clk);
    model_edge(r, d, rdy, res);
    #1;
    check_outputs();
  endtask

  typedef struct {
    bit rst, done, rdy, ff;
    bit e_valid, e_last, e_ovr, cd;
    int e_data, e_row, e_col;
  } vec_t;

  initial begin : main
    vec_t            vt[18];
    int              r, c, xfers;
    bit              rdy, hv;
    logic [RW-1:0]   hd;
    logic [1:0]      hr, hc;
    logic            hl;

    rst = 1'b1; done = 1'b0; out_ready = 1'b0; results = '0;

    // Reset, basic drain and snapshot isolation (results forced to all ones after capture).
    vt[0] = '{1,0,0,0, 0,0,0,1, 0,0,0};
    beat_rc(0, r, c);
    vt[1] = '{0,1,1,0, 1,0,0,1, exp_data(0,0), r, c};
    for (int k = 1; k <= N; k++) begin
      beat_rc(k % N, r, c);
      vt[1+k] = '{0,0,1,1, (k < N), (k == N-1), 0, (k < N),
                  (k < N) ? exp_data(0,k) : 0, r, c};
    end
    for (int i = 0; i < 18; i++) begin
      cyc(vt[i].rst, vt[i].done, vt[i].rdy, vt[i].ff ? {N*RW{1'b1}} : pat(0));
      chk("tv_valid", out_valid, vt[i].e_valid);
      chk("tv_last", out_last, vt[i].e_last);
      chk("tv_overrun", overrun, vt[i].e_ovr);
      if (vt[i].cd) begin
        chk("tv_data", out_data, vt[i].e_data);
        chk("tv_row", out_row, vt[i].e_row);
        chk("tv_col", out_col, vt[i].e_col);
      end
    end

    // Backpressure with ready pattern 1,0,0,1.
    cyc(0, 1, 0, pat(0));
    xfers = 0;
    for (int j = 0; j < 100 && xfers < N; j++) begin
      rdy = (j % 4 == 0) || (j % 4 == 3);
      hv = out_valid; hd = out_data; hr = out_row; hc = out_col; hl = out_last;
      if (hv && rdy) begin
        chk("bp_order", hd, exp_data(0, xfers));
        xfers++;
      end
      cyc(0, 0, rdy, rnd_res());
      if (hv && !rdy) begin
        chk("bp_hold_data", out_data, hd);
        chk("bp_hold_row", out_row, hr);
        chk("bp_hold_col", out_col, hc);
        chk("bp_hold_last", out_last, hl);
      end
    end
    chk("bp_xfers", xfers, N);
    chk("bp_idle", out_valid, 0);

    // Overrun: second done while beat 5 is presented.
    cyc(0, 1, 1, pat(0));
    for (int k = 0; k < N; k++) begin
      chk("ovr_order", out_data, exp_data(0, k));
      cyc(0, (k == 5), 1, pat(200));
      if (k == 5)   chk("ovr_set", overrun, 1);
      if (k == N-1) chk("ovr_valid_fall", out_valid, 0);
    end

    // Back-to-back: done on the final-beat transfer.
    cyc(1, 0, 0, pat(0));
    cyc(0, 1, 1, pat(0));
    for (int k = 0; k < N-1; k++) cyc(0, 0, 1, pat(0));
    chk("b2b_at_last", out_last, 1);
    cyc(0, 1, 1, pat(100));
    chk("b2b_no_ovr", overrun, 0);
    chk("b2b_valid", out_valid, 1);
    chk("b2b_first", out_data, 101);
    for (int k = 0; k < N+2; k++) cyc(0, 0, 1, rnd_res());

    // Reset mid-stream after a forced overrun.
    cyc(0, 1, 1, pat(0));
    cyc(0, 1, 1, pat(50));
    chk("rst_pre_ovr", overrun, 1);
    for (int k = 0; k < 6; k++) cyc(0, 0, 1, pat(0));
    chk("rst_at_beat7", out_data, exp_data(0, 7));
    cyc(1, 0, 1, pat(0));
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovr", overrun, 0);
    cyc(0, 1, 1, pat(300));
    chk("rst_restart_valid", out_valid, 1);
    chk("rst_restart_row", out_row, 0);
    chk("rst_restart_col", out_col, 0);
    chk("rst_restart_data", out_data, 301);

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++)
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 11) == 0,
          $urandom_range(0, 9) < 7, rnd_res());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
